tlb_tag_store: RTL

Fully-associative, Sv39 TLB tag store that writes and maintains the per-entry tag state (asid, vpn2/vpn1/vpn0, is_2M, is_1G, valid) that the core coverage monitors sample. It sits beside the MMU page-table walker. It accepts fills from the walker, answers registered lookups, and applies sfence.vma-style flushes. It exports the whole tag array as a flat vector packed in the coverage tag layout, so monitors can bind to it directly.

---
 rtl/tlb_tag_store.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/tlb_tag_store.sv
// Fully-associative Sv39 TLB tag store: walker fills, registered lookups and
// sfence.vma-style flushes, with the whole tag array exported in coverage layout.
module tlb_tag_store #(
    parameter int TLB_ENTRIES = 16,
    parameter int ASID_WIDTH  = 16,
    localparam int IDX_W      = $clog2(TLB_ENTRIES),
    localparam int TAG_W      = ASID_WIDTH + 30
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          lu_req_i,
    input  logic [26:0]                   lu_vpn_i,
    input  logic [ASID_WIDTH-1:0]         lu_asid_i,
    output logic                          lu_hit_o,
    output logic [IDX_W-1:0]              lu_hit_idx_o,
    output logic                          lu_is_2M_o,
    output logic                          lu_is_1G_o,
    input  logic                          upd_valid_i,
    output logic                          upd_ready_o,
    input  logic [26:0]                   upd_vpn_i,
    input  logic [ASID_WIDTH-1:0]         upd_asid_i,
    input  logic                          upd_is_2M_i,
    input  logic                          upd_is_1G_i,
    input  logic                          flush_i,
    input  logic                          flush_asid_valid_i,
    input  logic                          flush_vpn_valid_i,
    input  logic [ASID_WIDTH-1:0]         flush_asid_i,
    input  logic [26:0]                   flush_vpn_i,
    output logic [TLB_ENTRIES*TAG_W-1:0]  tags_o,
    output logic [IDX_W:0]                valid_cnt_o
);

    logic [ASID_WIDTH-1:0]  asid_q [TLB_ENTRIES];
    logic [ASID_WIDTH-1:0]  asid_d [TLB_ENTRIES];
    logic [26:0]            vpn_q  [TLB_ENTRIES];
    logic [26:0]            vpn_d  [TLB_ENTRIES];
    logic [TLB_ENTRIES-1:0] is_2m_q, is_2m_d;
    logic [TLB_ENTRIES-1:0] is_1g_q, is_1g_d;
    logic [TLB_ENTRIES-1:0] valid_q, valid_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   lu_hit_q, lu_hit_d;
    logic [IDX_W-1:0]       lu_idx_q, lu_idx_d;
    logic                   lu_2m_q, lu_2m_d;
    logic                   lu_1g_q, lu_1g_d;
    logic [IDX_W:0]         valid_cnt_q, valid_cnt_d;

    logic [TLB_ENTRIES-1:0] lu_match, upd_match, flush_hit;
    logic [IDX_W-1:0]       lu_first, upd_first, inv_first, victim;
    logic                   fill_go;

    // Size-aware VPN compare: a 1G page ignores vpn1/vpn0, a 2M page ignores vpn0.
    function automatic logic vpn_match(input logic [26:0] e_vpn, input logic e_2m,
                                       input logic e_1g, input logic [26:0] vpn);
        return (e_vpn[26:18] == vpn[26:18]) &&
               (e_1g || ((e_vpn[17:9] == vpn[17:9]) && (e_2m || (e_vpn[8:0] == vpn[8:0]))));
    endfunction

    generate
        for (genvar gi = 0; gi < TLB_ENTRIES; gi++) begin : g_entry
            assign lu_match[gi]  = valid_q[gi] && (asid_q[gi] == lu_asid_i) &&
                                   vpn_match(vpn_q[gi], is_2m_q[gi], is_1g_q[gi], lu_vpn_i);
            assign upd_match[gi] = valid_q[gi] && (asid_q[gi] == upd_asid_i) &&
                                   vpn_match(vpn_q[gi], is_2m_q[gi], is_1g_q[gi], upd_vpn_i) &&
                                   (is_2m_q[gi] == upd_is_2M_i) && (is_1g_q[gi] == upd_is_1G_i);
            assign flush_hit[gi] = (!flush_asid_valid_i || (asid_q[gi] == flush_asid_i)) &&
                                   (!flush_vpn_valid_i ||
                                    vpn_match(vpn_q[gi], is_2m_q[gi], is_1g_q[gi], flush_vpn_i));
            assign tags_o[gi*TAG_W +: TAG_W] = {asid_q[gi], vpn_q[gi], is_2m_q[gi],
                                                is_1g_q[gi], valid_q[gi]};
        end
    endgenerate

    // Lowest-index priority encoders: scanning downward leaves the lowest set bit.
    always_comb begin
        lu_first  = '0;
        upd_first = '0;
        inv_first = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (lu_match[i])  lu_first  = IDX_W'(i);
            if (upd_match[i]) upd_first = IDX_W'(i);
            if (!valid_q[i])  inv_first = IDX_W'(i);
        end
    end

    assign upd_ready_o = !flush_i;
    assign fill_go     = upd_valid_i && !flush_i;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        victim   = rr_ptr_q;
        if (|upd_match) begin
            victim = upd_first;
        end else if (!(&valid_q)) begin
            victim = inv_first;
        end else if (fill_go) begin
            rr_ptr_d = rr_ptr_q + IDX_W'(1);
        end
    end

    // Fill and flush are mutually exclusive since a fill is refused under flush.
    always_comb begin
        is_2m_d = is_2m_q;
        is_1g_d = is_1g_q;
        valid_d = valid_q;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            asid_d[i] = asid_q[i];
            vpn_d[i]  = vpn_q[i];
        end
        if (flush_i) begin
            valid_d = valid_q & ~flush_hit;
        end else if (fill_go) begin
            asid_d[victim]  = upd_asid_i;
            vpn_d[victim]   = upd_vpn_i;
            is_2m_d[victim] = upd_is_2M_i;
            is_1g_d[victim] = upd_is_1G_i;
            valid_d[victim] = 1'b1;
        end
        valid_cnt_d = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            valid_cnt_d = valid_cnt_d + (IDX_W + 1)'(valid_d[i]);
        end
    end

    always_comb begin
        lu_hit_d = lu_req_i && (|lu_match);
        lu_idx_d = lu_idx_q;
        lu_2m_d  = lu_2m_q;
        lu_1g_d  = lu_1g_q;
        if (lu_hit_d) begin
            lu_idx_d = lu_first;
            lu_2m_d  = is_2m_q[lu_first];
            lu_1g_d  = is_1g_q[lu_first];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                asid_q[i] <= '0;
                vpn_q[i]  <= '0;
            end
            is_2m_q     <= '0;
            is_1g_q     <= '0;
            valid_q     <= '0;
            rr_ptr_q    <= '0;
            lu_hit_q    <= 1'b0;
            lu_idx_q    <= '0;
            lu_2m_q     <= 1'b0;
            lu_1g_q     <= 1'b0;
            valid_cnt_q <= '0;
        end else begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                asid_q[i] <= asid_d[i];
                vpn_q[i]  <= vpn_d[i];
            end
            is_2m_q     <= is_2m_d;
            is_1g_q     <= is_1g_d;
            valid_q     <= valid_d;
            rr_ptr_q    <= rr_ptr_d;
            lu_hit_q    <= lu_hit_d;
            lu_idx_q    <= lu_idx_d;
            lu_2m_q     <= lu_2m_d;
            lu_1g_q     <= lu_1g_d;
            valid_cnt_q <= valid_cnt_d;
        end
    end

    assign lu_hit_o     = lu_hit_q;
    assign lu_hit_idx_o = lu_idx_q;
    assign lu_is_2M_o   = lu_2m_q;
    assign lu_is_1G_o   = lu_1g_q;
    assign valid_cnt_o  = valid_cnt_q;

endmodule
